// File: rtl/alu.sv
// 32-bit execute-stage ALU: seven operations selected by f.
// The result and zero flag are registered, giving one cycle of latency.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  f,
    output logic [31:0] y,
    output logic        zero
);

    logic [31:0] bb;
    logic [31:0] sum;
    logic [31:0] y_next;

    // Signed less-than from the subtractor output. The raw sign bit is
    // wrong when a - b overflows, so it is flipped in that case.
    function automatic logic slt_bit(input logic [31:0] op_a,
                                     input logic [31:0] op_b,
                                     input logic [31:0] diff);
        logic ovf;
        ovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
        return diff[31] ^ ovf;
    endfunction

    // Shared adder with optional B inversion; f[1:0] then picks the result.
    always_comb begin
        bb     = f[2] ? ~b : b;
        sum    = a + bb + {31'd0, f[2]};
        y_next = 32'd0;
        unique case (f[1:0])
            2'b00:   y_next = a & bb;
            2'b01:   y_next = a | bb;
            2'b10:   y_next = sum;
            2'b11:   y_next = f[2] ? {31'd0, slt_bit(a, b, sum)} : 32'd0;
            default: y_next = 32'd0;
        endcase
    end

    // Register the result; zero is derived from the same next value so
    // the two outputs always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            y    <= 32'd0;
            zero <= 1'b1;
        end else begin
            y    <= y_next;
            zero <= (y_next == 32'd0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] y;
    logic        zero;

    int checks;
    int failures;

    alu dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .f    (f),
        .y    (y),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written directly from the operation table.
    function automatic logic [31:0] model(input logic [31:0] ma,
                                          input logic [31:0] mb,
                                          input logic [2:0]  mf);
        case (mf)
            3'd0:    return ma & mb;
            3'd1:    return ma | mb;
            3'd2:    return ma + mb;
            3'd3:    return 32'd0;
            3'd4:    return ma & ~mb;
            3'd5:    return ma | ~mb;
            3'd6:    return ma - mb;
            default: return ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Apply inputs away from the active edge, then settle after the edge.
    task automatic step(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [2:0] tf, input logic trst);
        @(negedge clk);
        a   = ta;
        b   = tb_v;
        f   = tf;
        rst = trst;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp_y,
                         input logic exp_zero);
        checks++;
        assert (y === exp_y) else begin
            failures++;
            $error("FAIL %s y observed=%h expected=%h", tag, y, exp_y);
        end
        checks++;
        assert (zero === exp_zero) else begin
            failures++;
            $error("FAIL %s zero observed=%b expected=%b", tag, zero, exp_zero);
        end
    endtask

    task automatic step_model(input string tag, input logic [31:0] ta,
                              input logic [31:0] tb_v, input logic [2:0] tf,
                              input logic trst);
        logic [31:0] e;
        step(ta, tb_v, tf, trst);
        e = trst ? 32'd0 : model(ta, tb_v, tf);
        check(tag, e, e == 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, held_y;
        logic [2:0]  rf;
        logic        rr, held_z;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a   = 32'hFFFF_FFFF;
        b   = 32'h0000_0001;
        f   = 3'b010;

        // Reset held for two edges overrides a live add
        step(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b1);
        check("reset1", 32'h0, 1'b1);
        step(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b1);
        check("reset2", 32'h0, 1'b1);
        step(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b0);
        check("reset_release_wrap", 32'h0, 1'b1);

        // Add / sub
        step(32'h0000_0001, 32'hFFFF_FFFF, 3'b010, 1'b0);
        check("add_wrap", 32'h0, 1'b1);
        step(32'h0000_0000, 32'h0000_0001, 3'b110, 1'b0);
        check("sub_neg", 32'hFFFF_FFFF, 1'b0);
        step(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 1'b0);
        check("add_ovf", 32'h8000_0000, 1'b0);

        // Logic
        step(32'hFFFF_FFFF, 32'h1234_5678, 3'b000, 1'b0);
        check("and", 32'h1234_5678, 1'b0);
        step(32'hFFFF_FFFF, 32'h1234_5678, 3'b001, 1'b0);
        check("or", 32'hFFFF_FFFF, 1'b0);
        step(32'hFFFF_FFFF, 32'h1234_5678, 3'b100, 1'b0);
        check("andnot", 32'hEDCB_A987, 1'b0);
        step(32'hFFFF_FFFF, 32'h1234_5678, 3'b101, 1'b0);
        check("ornot", 32'hFFFF_FFFF, 1'b0);
        step(32'h0000_0000, 32'hFFFF_FFFF, 3'b000, 1'b0);
        check("and_zero", 32'h0, 1'b1);

        // Signed less-than, including the overflow-corrected case
        step(32'hFFFF_FFFF, 32'h0000_0000, 3'b111, 1'b0);
        check("slt_neg_lt_zero", 32'h1, 1'b0);
        step(32'h0000_0000, 32'hFFFF_FFFF, 3'b111, 1'b0);
        check("slt_zero_gt_neg", 32'h0, 1'b1);
        step(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1'b0);
        check("slt_ovf_min", 32'h1, 1'b0);
        step(32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 1'b0);
        check("slt_ovf_max", 32'h0, 1'b1);
        step(32'h0000_0005, 32'h0000_0005, 3'b111, 1'b0);
        check("slt_equal", 32'h0, 1'b1);

        // Reserved code yields a defined zero
        step(32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 1'b0);
        check("reserved", 32'h0, 1'b1);

        // Back-to-back through all eight codes with changing operands
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            step_model($sformatf("b2b_f%0d", i), ra, rb, 3'(i), 1'b0);
        end

        // Outputs hold when inputs change between edges
        held_y = y;
        held_z = zero;
        a = ~a;
        b = b + 32'd3;
        f = f ^ 3'b101;
        #3;
        check("hold_between_edges", held_y, held_z);

        // One-edge reset in the middle of a stream, then resume
        step_model("stream_pre", 32'h0000_0010, 32'h0000_0003, 3'b110, 1'b0);
        step_model("stream_rst", 32'h0000_0010, 32'h0000_0003, 3'b110, 1'b1);
        step_model("stream_post", 32'h0000_0010, 32'h0000_0003, 3'b110, 1'b0);
        check("stream_post_value", 32'h0000_000D, 1'b0);

        // Randomized operations, with operands biased toward sign boundaries
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'h7FFF_FFFF;
                2: rb = ra;
                3: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            rf = 3'($urandom_range(0, 7));
            rr = ($urandom_range(0, 19) == 0);
            step_model($sformatf("rand%0d_f%0d", i, rf), ra, rb, rf, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
